gin_mc_network: RTL and testbench

//  Parametrised global input network. It multicasts operand packets from the GLB/SRAM side to an
//  NUM_ROWS x NUM_COLS PE array, using tag/ID matching (row YID, per-PE XID).
//  It adds three things: a packet FIFO, a separate data lane per row, and all-targets-accept
//  (partial-ready) tracking. It also adds an optional broadcast wildcard and a drop/error report
//  for packets that match no PE.

---
 rtl/gin_pkg.sv | 17 +
 rtl/gin_pkt_fifo.sv | 46 ++++
 rtl/gin_mc_network.sv | 135 +++++++++++++
 tb/tb_gin_mc_network.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gin_pkg.sv
// Shared defaults and types for the global input multicast network.
package gin_pkg;
    localparam int GIN_DATA_BITS = 32;
    localparam int GIN_XID_BITS  = 5;
    localparam int GIN_YID_BITS  = 4;

    typedef struct packed {
        logic [GIN_DATA_BITS-1:0] data;
        logic [GIN_YID_BITS-1:0]  tag_y;
        logic [GIN_XID_BITS-1:0]  tag_x;
    } gin_pkt_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } gin_state_e;
endpackage

// File: rtl/gin_pkt_fifo.sv
// Synchronous packet FIFO; pointers carry one wrap bit so full/empty come from a compare.
module gin_pkt_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/gin_mc_network.sv
// Global input network: queues tagged packets and multicasts the head to every PE whose
// row/column IDs match, holding the head until all matched PEs have accepted it.
module gin_mc_network
    import gin_pkg::*;
#(
    parameter int NUM_ROWS   = 6,
    parameter int NUM_COLS   = 8,
    parameter int DATA_BITS  = GIN_DATA_BITS,
    parameter int XID_BITS   = GIN_XID_BITS,
    parameter int YID_BITS   = GIN_YID_BITS,
    parameter int FIFO_DEPTH = 4,
    parameter bit BCAST_EN   = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              GIN_valid,
    output logic                              GIN_ready,
    input  logic [DATA_BITS-1:0]              GIN_data,
    input  logic [XID_BITS-1:0]               tag_X,
    input  logic [YID_BITS-1:0]               tag_Y,
    input  logic                              set_XID,
    input  logic [XID_BITS-1:0]               XID_scan_in,
    input  logic                              set_YID,
    input  logic [YID_BITS-1:0]               YID_scan_in,
    output logic                              cfg_ready,
    input  logic [NUM_ROWS*NUM_COLS-1:0]      PE_ready,
    output logic [NUM_ROWS*NUM_COLS-1:0]      PE_valid,
    output logic [NUM_ROWS*DATA_BITS-1:0]     PE_data,
    output logic                              busy,
    output logic                              drop_pulse
);
    localparam int N  = NUM_ROWS * NUM_COLS;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic [YID_BITS-1:0]  tag_y;
        logic [XID_BITS-1:0]  tag_x;
    } pkt_t;

    pkt_t        push_pkt, head;
    logic        full, empty, push_ok, pop;
    logic [AW:0] fifo_cnt;

    gin_state_e  state_q, state_d;
    logic [N-1:0] done_mask_q, done_mask_d;
    logic [N-1:0] target, accept;

    logic [YID_BITS-1:0] yid_q [NUM_ROWS];
    logic [XID_BITS-1:0] xid_q [N];

    assign push_pkt = '{data: GIN_data, tag_y: tag_Y, tag_x: tag_X};
    assign push_ok  = GIN_valid && !full;

    gin_pkt_fifo #(
        .WIDTH($bits(pkt_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok),
        .wdata_i (push_pkt),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_cnt),
        .head_o  (head)
    );

    assign GIN_ready = !full;
    assign busy      = !empty;
    assign cfg_ready = (state_q == IDLE) && empty;

    // Both ID chains shift only while nothing is queued, so a live match never sees a moving ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) yid_q[r] <= '0;
            for (int i = 0; i < N; i++)        xid_q[i] <= '0;
        end else begin
            if (set_YID && cfg_ready) begin
                yid_q[0] <= YID_scan_in;
                for (int r = 1; r < NUM_ROWS; r++) yid_q[r] <= yid_q[r-1];
            end
            if (set_XID && cfg_ready) begin
                xid_q[0] <= XID_scan_in;
                for (int i = 1; i < N; i++) xid_q[i] <= xid_q[i-1];
            end
        end
    end

    logic bc_y, bc_x;
    assign bc_y = BCAST_EN && (&head.tag_y);
    assign bc_x = BCAST_EN && (&head.tag_x);

    genvar r, c;
    generate
        for (r = 0; r < NUM_ROWS; r++) begin : g_row
            logic hit_y, row_vld;
            assign hit_y   = bc_y || (yid_q[r] == head.tag_y);
            for (c = 0; c < NUM_COLS; c++) begin : g_col
                assign target[r*NUM_COLS+c] =
                    hit_y && (bc_x || (xid_q[r*NUM_COLS+c] == head.tag_x));
            end
            assign row_vld = |PE_valid[r*NUM_COLS +: NUM_COLS];
            assign PE_data[r*DATA_BITS +: DATA_BITS] = row_vld ? head.data : '0;
        end
    endgenerate

    assign PE_valid   = target & ~done_mask_q & {N{!empty}};
    assign accept     = PE_valid & PE_ready;
    // An empty target set satisfies the completion test at once, which is the drop path.
    assign pop        = !empty && ((done_mask_q | accept) == target);
    assign drop_pulse = !empty && (target == '0);

    assign done_mask_d = pop ? '0 : (done_mask_q | accept);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push_ok) state_d = SEND;
            SEND:    if (pop && !push_ok && fifo_cnt == {{AW{1'b0}}, 1'b1}) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            done_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            done_mask_q <= done_mask_d;
        end
    end
endmodule

// File: tb/tb_gin_mc_network.sv
// Self-checking bench: constant vector table, directed multi-cycle sequences and a
// randomized run, all compared every cycle against a queue-based packet model.
module tb_gin_mc_network;
    localparam int R = 6, C = 8, N = 48, DW = 32;

    logic          clk, rst, GIN_valid, GIN_ready, set_XID, set_YID, cfg_ready, busy, drop_pulse;
    logic [DW-1:0] GIN_data;
    logic [4:0]    tag_X, XID_scan_in;
    logic [3:0]    tag_Y, YID_scan_in;
    logic [N-1:0]  PE_ready, PE_valid;
    logic [R*DW-1:0] PE_data;

    gin_mc_network #(
        .NUM_ROWS(R), .NUM_COLS(C), .DATA_BITS(DW), .XID_BITS(5), .YID_BITS(4),
        .FIFO_DEPTH(4), .BCAST_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .GIN_valid(GIN_valid), .GIN_ready(GIN_ready),
        .GIN_data(GIN_data), .tag_X(tag_X), .tag_Y(tag_Y),
        .set_XID(set_XID), .XID_scan_in(XID_scan_in),
        .set_YID(set_YID), .YID_scan_in(YID_scan_in), .cfg_ready(cfg_ready),
        .PE_ready(PE_ready), .PE_valid(PE_valid), .PE_data(PE_data),
        .busy(busy), .drop_pulse(drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // Reference model: packet queue, per-packet delivered set, ID arrays.
    logic [31:0] qd[$];
    logic [3:0]  qy[$];
    logic [4:0]  qx[$];
    logic [N-1:0] dlv;
    logic [3:0]  ym[R];
    logic [4:0]  xm[N];

    typedef struct {
        logic [3:0]   ty;
        logic [4:0]   tx;
        logic [31:0]  d;
        logic [N-1:0] vmask;
        logic         drop;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] m_target();
        logic [N-1:0] t;
        t = '0;
        if (qd.size() == 0) return t;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if ((ym[r] == qy[0] || qy[0] == 4'hF) && (xm[r*C+c] == qx[0] || qx[0] == 5'h1F))
                    t[r*C+c] = 1'b1;
        return t;
    endfunction

    task automatic model_clear();
        qd.delete(); qy.delete(); qx.delete();
        dlv = '0;
        for (int r = 0; r < R; r++) ym[r] = '0;
        for (int i = 0; i < N; i++) xm[i] = '0;
    endtask

    task automatic check_outputs();
        int sz;
        logic [N-1:0] tgt, vld;
        logic [191:0] pd;
        sz  = qd.size();
        tgt = m_target();
        vld = (sz > 0) ? (tgt & ~dlv) : '0;
        pd  = '0;
        for (int r = 0; r < R; r++)
            if (|vld[r*C +: C]) pd[r*DW +: DW] = qd[0];
        chk("gin_ready", 192'(GIN_ready), 192'(sz < 4));
        chk("busy",      192'(busy),      192'(sz > 0));
        chk("cfg_ready", 192'(cfg_ready), 192'(sz == 0));
        chk("pe_valid",  192'(PE_valid),  192'(vld));
        chk("pe_data",   PE_data,         pd);
        chk("drop",      192'(drop_pulse), 192'(sz > 0 && tgt == '0));
    endtask

    task automatic model_step();
        int sz;
        logic [N-1:0] tgt, acc;
        sz  = qd.size();
        tgt = m_target();
        acc = (sz > 0) ? (tgt & ~dlv & PE_ready) : '0;
        if (sz > 0) begin
            if ((dlv | acc) == tgt) begin
                void'(qd.pop_front()); void'(qy.pop_front()); void'(qx.pop_front());
                dlv = '0;
            end else begin
                dlv = dlv | acc;
            end
        end
        if (GIN_valid && sz < 4) begin
            qd.push_back(GIN_data); qy.push_back(tag_Y); qx.push_back(tag_X);
        end
        if (sz == 0) begin
            if (set_YID) begin
                for (int r = R-1; r > 0; r--) ym[r] = ym[r-1];
                ym[0] = YID_scan_in;
            end
            if (set_XID) begin
                for (int i = N-1; i > 0; i--) xm[i] = xm[i-1];
                xm[0] = XID_scan_in;
            end
        end
    endtask

    // Called at posedge+1 with this cycle's inputs already driven.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        GIN_valid = 1'b0; set_XID = 1'b0; set_YID = 1'b0;
        GIN_data = '0; tag_X = '0; tag_Y = '0; XID_scan_in = '0; YID_scan_in = '0;
        PE_ready = '1;
    endtask

    task automatic push(input logic [3:0] ty, input logic [4:0] tx, input logic [31:0] d);
        GIN_valid = 1'b1; tag_Y = ty; tag_X = tx; GIN_data = d;
    endtask

    task automatic load_ids(input bit xzero, input bit doy);
        for (int k = 0; k < N; k++) begin
            set_XID = 1'b1;
            XID_scan_in = xzero ? 5'd0 : 5'((47 - k) % 8);
            set_YID = doy && (k < R);
            YID_scan_in = 4'((5 - k) & 15);
            cycle();
        end
        set_XID = 1'b0; set_YID = 1'b0;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_valid"}, 192'(PE_valid), 192'(0));
        chk({nm, "_data"},  PE_data, 192'(0));
        chk({nm, "_busy"},  192'(busy), 192'(0));
        chk({nm, "_ready"}, 192'(GIN_ready), 192'(1));
        chk({nm, "_cfg"},   192'(cfg_ready), 192'(1));
        chk({nm, "_drop"},  192'(drop_pulse), 192'(0));
    endtask

    initial begin
        logic [191:0] lanes;
        tbl[0] = '{4'd2,  5'd3,    32'hA5A5_0001, 48'h0000_0008_0000, 1'b0};
        tbl[1] = '{4'd0,  5'd0,    32'h1111_0000, 48'h0000_0000_0001, 1'b0};
        tbl[2] = '{4'd5,  5'd7,    32'h5555_0007, 48'h8000_0000_0000, 1'b0};
        tbl[3] = '{4'd9,  5'd0,    32'hDEAD_0009, 48'h0000_0000_0000, 1'b1};
        tbl[4] = '{4'd3,  5'h1F,   32'h3333_001F, 48'h0000_FF00_0000, 1'b0};
        tbl[5] = '{4'hF,  5'h1F,   32'hBCBC_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0};
        tbl[6] = '{4'hF,  5'd2,    32'hC0C0_0002, 48'h0404_0404_0404, 1'b0};
        tbl[7] = '{4'd1,  5'd9,    32'hD0D0_0019, 48'h0000_0000_0000, 1'b1};

        idle_in();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        #1;
        chk_reset_state("reset");

        // Unicast / broadcast / drop vectors with IDs YID[r]=r, XID[r][c]=c.
        load_ids(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].ty, tbl[i].tx, tbl[i].d);
            cycle();
            GIN_valid = 1'b0;
            #1;
            lanes = '0;
            for (int r = 0; r < R; r++)
                if (|tbl[i].vmask[r*C +: C]) lanes[r*DW +: DW] = tbl[i].d;
            chk("tbl_valid", 192'(PE_valid), 192'(tbl[i].vmask));
            chk("tbl_drop",  192'(drop_pulse), 192'(tbl[i].drop));
            chk("tbl_data",  PE_data, lanes);
            cycle();
            #1;
            chk("tbl_busy_after", 192'(busy), 192'(0));
        end

        // Row multicast with split acceptance.
        load_ids(1'b1, 1'b0);
        push(4'd1, 5'd0, 32'h2222_0001);
        cycle();
        GIN_valid = 1'b0;
        PE_ready = 48'h0000_0000_0F00;
        #1; chk("mc_c1_valid", 192'(PE_valid), 192'(48'h0000_0000_FF00));
        cycle();
        #1; chk("mc_c2_valid", 192'(PE_valid), 192'(48'h0000_0000_F000));
        cycle();
        PE_ready = '1;
        #1; chk("mc_c3_valid", 192'(PE_valid), 192'(48'h0000_0000_F000));
        cycle();
        #1;
        chk("mc_done_valid", 192'(PE_valid), 192'(0));
        chk("mc_done_busy",  192'(busy), 192'(0));

        // Back-pressure: fill, stall a 5th push, ignored config, drain in order.
        PE_ready = '0;
        for (int k = 0; k < 4; k++) begin
            push(4'd0, 5'd0, 32'h5000_0000 + 32'(k));
            cycle();
        end
        #1; chk("full_ready", 192'(GIN_ready), 192'(0));
        push(4'd0, 5'd0, 32'h0BAD_0BAD);
        set_XID = 1'b1; XID_scan_in = 5'd7;
        cycle();
        GIN_valid = 1'b0; set_XID = 1'b0;
        cycle();
        PE_ready = '1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_data",  192'(PE_data[31:0]), 192'(32'h5000_0000 + 32'(k)));
            chk("drain_valid", 192'(PE_valid), 192'(48'h0000_0000_00FF));
            cycle();
        end
        #1; chk("drain_busy", 192'(busy), 192'(0));
        push(4'd0, 5'd0, 32'h600D_0000);
        cycle();
        GIN_valid = 1'b0;
        #1; chk("ids_kept", 192'(PE_valid), 192'(48'h0000_0000_00FF));
        cycle();

        // Reset with two packets queued and a partial done set.
        PE_ready = '0;
        push(4'd1, 5'd0, 32'h7777_0001); cycle();
        push(4'd1, 5'd0, 32'h7777_0002); cycle();
        GIN_valid = 1'b0;
        PE_ready = 48'h0000_0000_0300;
        cycle();
        idle_in();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        #1;
        chk_reset_state("midrst");
        push(4'd0, 5'd0, 32'h8888_0000);
        cycle();
        GIN_valid = 1'b0;
        #1; chk("ids_zero", 192'(PE_valid), 192'(48'hFFFF_FFFF_FFFF));
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            GIN_valid   = 1'($urandom_range(0, 1));
            tag_Y       = ($urandom_range(0, 7) == 0) ? 4'hF  : 4'($urandom_range(0, 4));
            tag_X       = ($urandom_range(0, 7) == 0) ? 5'h1F : 5'($urandom_range(0, 3));
            GIN_data    = $urandom;
            PE_ready    = ($urandom_range(0, 3) == 0) ? '1 : 48'({$urandom, $urandom});
            set_XID     = ($urandom_range(0, 3) == 0);
            set_YID     = ($urandom_range(0, 3) == 0);
            XID_scan_in = 5'($urandom_range(0, 3));
            YID_scan_in = 4'($urandom_range(0, 3));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
